// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared down-counter.
// The block drives grant/done/busy/count; the requester side drives req/req_count/pause.
interface timer_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 5
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*COUNT_WIDTH-1:0] req_count;
    logic                           pause;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic                           busy;
    logic [COUNT_WIDTH-1:0]         count;

    modport master (
        output req, req_count, pause,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, req_count, pause,
        output grant, done, busy, count
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one pausable down-counter between NUM_REQ requesters.
// A winner owns the counter until it completes (done pulse) or drops its request.
module timer_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 5
) (
    input logic             clk,
    input logic             rst,
    timer_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   busy_q, busy_d;

    logic [IDX_W-1:0]       pick;
    logic                   pick_valid;

    // First requester found scanning upward from the one after the last owner.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(last_q) + i) % NUM_REQ;
            cand = IDX_W'(idx);
            if (!pick_valid && bus.req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!bus.req[winner_q]) begin
                    last_d  = winner_q;
                    state_d = S_IDLE;
                end else begin
                    count_d = bus.req_count[32'(winner_q)*COUNT_WIDTH +: COUNT_WIDTH];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Abort wins over completion; a paused counter at zero still finishes.
                if (!bus.req[winner_q]) begin
                    last_d  = winner_q;
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                end else if (!bus.pause) begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                last_d  = winner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        grant_d = '0;
        done_d  = '0;
        busy_d  = (state_d != S_IDLE);
        if (busy_d) begin
            grant_d[winner_d] = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d[winner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            count_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: expected done pulses are queued as requests are driven
// and matched (vector, cycle, grant) whenever the block pulses done.
module tb_timer_arbiter;
    localparam int NR = 4;
    localparam int CW = 5;

    typedef struct {
        logic [NR-1:0] vec;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    timer_arbiter_if #(.NUM_REQ(NR), .COUNT_WIDTH(CW)) bus ();

    timer_arbiter #(.NUM_REQ(NR), .COUNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input int at_cyc);
        exp_t e;
        e.vec      = '0;
        e.vec[idx] = 1'b1;
        e.cyc      = at_cyc;
        sb.push_back(e);
    endtask

    task automatic set_slice(input int idx, input int val);
        bus.req_count[idx*CW +: CW] = CW'(val);
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("sb_timeout", 32'(sb.size()), 0);
    endtask

    task automatic wait_count(input int val, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.busy && bus.count == CW'(val)) && n < budget);
        if (!(bus.busy && bus.count == CW'(val))) check("count_timeout", 32'(bus.count), 32'(val));
    endtask

    // Every done pulse must have been predicted, at the predicted cycle, with matching grant.
    always @(negedge clk) begin
        if (!rst && bus.done != '0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(bus.done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_vec", 32'(bus.done), 32'(e.vec));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("grant_at_done", 32'(bus.grant), 32'(e.vec));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_count = '0;
        bus.pause     = 1'b0;
        #2;
        check("rst_count", 32'(bus.count), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request, duration 3
        @(negedge clk);
        c = cyc;
        bus.req = 4'b0001;
        set_slice(0, 3);
        push_exp(0, c + 6);
        @(negedge clk);
        check("t1_grant", 32'(bus.grant), 32'h1);
        check("t1_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_count", 32'(bus.count), 32'(3 - k));
        end
        @(negedge clk);
        #1;
        check("t1_sb", 32'(sb.size()), 0);
        bus.req = '0;
        @(negedge clk);
        check("t1_busy_low", 32'(bus.busy), 0);
        check("t1_grant_low", 32'(bus.grant), 0);

        // Fresh reset, then all four requesting with duration 1
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        c = cyc;
        bus.req = 4'b1111;
        for (int i = 0; i < NR; i++) set_slice(i, 1);
        for (int k = 0; k < 5; k++) push_exp(k % NR, c + 4 + 5 * k);
        wait_sb_empty(60);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Pause for three edges during COUNT
        @(negedge clk);
        c = cyc;
        bus.req = 4'b0100;
        set_slice(2, 2);
        push_exp(2, c + 8);
        repeat (2) @(negedge clk);
        check("t3_loaded", 32'(bus.count), 2);
        bus.pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold", 32'(bus.count), 2);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        check("t3_resume", 32'(bus.count), 1);
        wait_sb_empty(20);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Abort at count 5: no done, count holds
        bus.req = 4'b0010;
        set_slice(1, 9);
        wait_count(5, 40);
        bus.req = '0;
        @(negedge clk);
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_grant", 32'(bus.grant), 0);
        check("t4_count", 32'(bus.count), 5);
        @(negedge clk);
        check("t4_count_hold", 32'(bus.count), 5);

        // Abort made 1 the last owner, so 2 goes before 0
        @(negedge clk);
        c = cyc;
        bus.req = 4'b0101;
        set_slice(0, 0);
        set_slice(2, 0);
        push_exp(2, c + 3);
        push_exp(0, c + 7);
        wait_sb_empty(30);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Zero duration with pause held high the whole time
        @(negedge clk);
        c = cyc;
        bus.req   = 4'b0010;
        bus.pause = 1'b1;
        set_slice(1, 0);
        push_exp(1, c + 3);
        wait_sb_empty(20);
        bus.pause = 1'b0;
        bus.req   = '0;
        repeat (3) @(negedge clk);

        // Async reset mid-COUNT, then req[0] beats req[3]
        bus.req = 4'b1000;
        set_slice(3, 9);
        wait_count(6, 40);
        #1 rst = 1'b1;
        #1;
        check("t5_count", 32'(bus.count), 0);
        check("t5_grant", 32'(bus.grant), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_busy", 32'(bus.busy), 0);
        bus.req = 4'b1001;
        set_slice(0, 0);
        set_slice(3, 0);
        #1 rst = 1'b0;
        c = cyc;
        push_exp(0, c + 3);
        push_exp(3, c + 7);
        wait_sb_empty(30);
        bus.req = '0;
        repeat (4) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameters SHALL be:
  - NUM_REQ, default 4, number of requesters (2..8).
  - COUNT_WIDTH, default 5, width of the shared down-counter.
REQ-002 Ports SHALL be:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - req  in  NUM_REQ  per-requester timer request, held high until done or abort.
  - req_count  in  NUM_REQ*COUNT_WIDTH  packed durations; slice i = bits [i*COUNT_WIDTH +: COUNT_WIDTH].
  - pause  in  1  freezes the shared counter while high.
  - grant  out  NUM_REQ  one-hot, owner of the shared counter.
  - done  out  NUM_REQ  one-cycle completion pulse to the owner.
  - busy  out  1  high in any state other than IDLE.
  - count  out  COUNT_WIDTH  current shared counter value.
REQ-003 The single clock domain is clk; the reset is asynchronous and active-high, port rst.

Function
REQ-004 The FSM SHALL have four states, encoded distinctly: IDLE, LOAD, COUNT, DONE.
REQ-005 IDLE: if any req bit is high at a clock edge, the block SHALL select one winner, register its index, and go to LOAD. Otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin. The search starts at index (last+1) mod NUM_REQ, where last is the most recently completed or aborted winner.
REQ-007 LOAD: count SHALL load the winner's req_count slice, and the FSM SHALL go to COUNT.
REQ-008 COUNT, at each edge:
  - if count==0, the FSM SHALL go to DONE;
  - else if pause==0, count SHALL decrement by 1;
  - else count SHALL hold.
REQ-009 DONE: done[winner] SHALL be high for exactly this one cycle. last SHALL be set to the winner, and the FSM SHALL return to IDLE.
REQ-010 grant[winner] SHALL be high in LOAD, COUNT and DONE. grant SHALL be zero in IDLE.
REQ-011 Latency: let E0 be the IDLE edge that samples req, with duration N and pause low throughout. Then:
  - done SHALL assert after edge E0+N+2;
  - busy SHALL fall after edge E0+N+3.
REQ-012 N=0 SHALL pass LOAD -> COUNT -> DONE with no decrement, so done asserts after edge E0+2.
REQ-013 count SHALL never wrap below zero. Decrementing is suppressed at 0.
REQ-014 Changes to req_count after the LOAD edge SHALL be ignored for the current grant.
REQ-015 Abort: if req[winner] is low at an edge in LOAD or COUNT, the FSM SHALL go to IDLE, and last SHALL be set to the winner. done SHALL not pulse and count SHALL hold its value.
REQ-016 Requests from non-winners SHALL wait. They are never dropped, and starvation SHALL be impossible: a requester holding req is served within NUM_REQ grants.
REQ-017 pause SHALL have no effect outside COUNT. pause held high in COUNT with count==0 SHALL still allow the transition to DONE.
REQ-018 done, grant and busy SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-019 While rst is high, independent of clk, the block SHALL hold:
  - state = IDLE;
  - count = 0, grant = 0, done = 0, busy = 0;
  - last = NUM_REQ-1, so req[0] has first priority.
REQ-020 rst asserted mid-operation SHALL abandon the grant with no done pulse. The first edge after rst release SHALL behave as IDLE.

Verification
REQ-021 Single request: req=4'b0001, slice0=3, pause=0.
  -> grant=0001 after E0+1; count runs 3,2,1,0; done=0001 one cycle after E0+5; busy low after E0+6.
REQ-022 Simultaneous requests: req=4'b1111 held, all durations=1.
  -> grants in order 0,1,2,3,0; each done pulses once per grant.
REQ-023 Pause: slice2=2, pause high for 3 cycles during COUNT.
  -> count holds during pause; done is delayed by exactly 3 cycles versus the no-pause case.
REQ-024 Zero duration and abort:
  - slice1=0 -> done[1] after E0+2.
  - Second request: req[1] dropped while count=5 -> IDLE next edge, no done, count stays 5.
REQ-025 Async reset: rst pulsed mid-COUNT between clock edges.
  -> count, grant, done and busy are 0 immediately; next request from req[0] wins over req[3].
